// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station.
// The entry structs use TAG_W_DEF, so alu_rs TAG_W must equal it.
package alu_rs_pkg;

  localparam int TAG_W_DEF = 6;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_SLT = 3'b111
  } alucont_t;

  typedef struct packed {
    logic                 rdy;
    logic [TAG_W_DEF-1:0] tag;
    logic [31:0]          value;
  } operand_t;

  typedef struct packed {
    logic                 valid;
    alucont_t             alucont;
    operand_t             a;
    operand_t             b;
    logic [TAG_W_DEF-1:0] dst_tag;
  } rs_entry_t;

  // Pending operand grabs a matching CDB result.
  function automatic operand_t capture(
    input operand_t             op,
    input logic                 cv,
    input logic [TAG_W_DEF-1:0] ct,
    input logic [31:0]          cd
  );
    capture = op;
    if (!op.rdy && cv && op.tag == ct) begin
      capture.rdy   = 1'b1;
      capture.value = cd;
    end
  endfunction

endpackage

// File: rtl/alu_rs_operand.sv
// One stored operand: CDB compare, capture and issue-time view.
// ALU_RS_WAKEUP_BYPASS_EN lets a same-cycle CDB hit count as ready.
module alu_rs_operand
  import alu_rs_pkg::*;
(
  input  operand_t             op,
  input  logic                 cdb_valid,
  input  logic [TAG_W_DEF-1:0] cdb_tag,
  input  logic [31:0]          cdb_data,
  output operand_t             nxt,
  output logic                 rdy_now,
  output logic [31:0]          val_now
);

  assign nxt = capture(op, cdb_valid, cdb_tag, cdb_data);

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  assign rdy_now = nxt.rdy;
  assign val_now = nxt.value;
`else
  assign rdy_now = op.rdy;
  assign val_now = op.value;
`endif

endmodule

// File: rtl/alu_rs.sv
// Collapsing-queue reservation station for one integer ALU.
// Optional: ALU_RS_WAKEUP_BYPASS_EN (issue in the wakeup cycle).
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [2:0]       disp_alucont,
  input  logic [31:0]      disp_a,
  input  logic [31:0]      disp_b,
  input  logic             disp_a_rdy,
  input  logic             disp_b_rdy,
  input  logic [TAG_W-1:0] disp_a_tag,
  input  logic [TAG_W-1:0] disp_b_tag,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_a,
  output logic [31:0]      iss_b,
  output logic [2:0]       iss_alucont,
  output logic [TAG_W-1:0] iss_dst_tag
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);

  rs_entry_t        q   [DEPTH];
  rs_entry_t        q_n [DEPTH];
  rs_entry_t        w   [DEPTH+1];
  rs_entry_t        din;
  operand_t         a_nxt [DEPTH];
  operand_t         b_nxt [DEPTH];
  logic [31:0]      a_val [DEPTH];
  logic [31:0]      b_val [DEPTH];
  logic [DEPTH-1:0] a_rn;
  logic [DEPTH-1:0] b_rn;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_after;
  logic [SW-1:0]    sel;
  logic             found;
  logic             fire_iss;
  logic             fire_disp;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    alu_rs_operand u_a (
      .op        (q[i].a),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt       (a_nxt[i]),
      .rdy_now   (a_rn[i]),
      .val_now   (a_val[i])
    );
    alu_rs_operand u_b (
      .op        (q[i].b),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt       (b_nxt[i]),
      .rdy_now   (b_rn[i]),
      .val_now   (b_val[i])
    );
    assign rdy[i] = q[i].valid & a_rn[i] & b_rn[i];
  end

  // Oldest ready entry wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        found = 1'b1;
        sel   = SW'(i);
      end
    end
  end

  assign iss_valid   = found;
  assign iss_a       = found ? a_val[sel] : '0;
  assign iss_b       = found ? b_val[sel] : '0;
  assign iss_alucont = found ? q[sel].alucont : '0;
  assign iss_dst_tag = found ? q[sel].dst_tag : '0;

  assign disp_ready = count < CW'(DEPTH);
  assign fire_iss   = iss_valid & iss_ready;
  assign fire_disp  = disp_valid & disp_ready;
  assign cnt_after  = count - CW'(fire_iss);

  always_comb begin
    din.valid   = 1'b1;
    din.alucont = alucont_t'(disp_alucont);
    din.a       = capture('{rdy: disp_a_rdy, tag: disp_a_tag,
                            value: disp_a},
                          cdb_valid, cdb_tag, cdb_data);
    din.b       = capture('{rdy: disp_b_rdy, tag: disp_b_tag,
                            value: disp_b},
                          cdb_valid, cdb_tag, cdb_data);
    din.dst_tag = disp_dst_tag;
  end

  // Wakeup first, then collapse over the issued slot, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i]   = q[i];
      w[i].a = a_nxt[i];
      w[i].b = b_nxt[i];
    end
    w[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_n[i] = (fire_iss && i >= int'(sel)) ? w[i+1] : w[i];
      if (fire_disp && i == int'(cnt_after))
        q_n[i] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q     <= '{default: '0};
      count <= '0;
    end else begin
      q     <= q_n;
      count <= cnt_after + CW'(fire_disp);
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed, table-driven bench for alu_rs.
// Expectations follow ALU_RS_WAKEUP_BYPASS_EN when it is defined.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_alucont;
  logic [31:0] disp_a, disp_b;
  logic        disp_a_rdy, disp_b_rdy;
  logic [5:0]  disp_a_tag, disp_b_tag, disp_dst_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_a, iss_b;
  logic [2:0]  iss_alucont;
  logic [5:0]  iss_dst_tag;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alucont(disp_alucont),
    .disp_a(disp_a), .disp_b(disp_b),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
    .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a(iss_a), .iss_b(iss_b),
    .iss_alucont(iss_alucont), .iss_dst_tag(iss_dst_tag)
  );

  typedef struct {
    bit        rs, fl, chk, dv;
    bit [2:0]  op;
    bit [31:0] a, b;
    bit        ar, br;
    bit [5:0]  at, bt, dst;
    bit        cv;
    bit [5:0]  ct;
    bit [31:0] cd;
    bit        ir;
    bit        e_dr, e_iv;
    bit [31:0] e_a, e_b;
    bit [2:0]  e_op;
    bit [5:0]  e_dst;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t nop(bit ir);
    vec_t t = '{default: 0};
    t.chk  = 1'b1;
    t.ir   = ir;
    t.e_dr = 1'b1;
    return t;
  endfunction

  function automatic vec_t dsp(vec_t t, bit [2:0] op,
      bit [31:0] a, bit ar, bit [5:0] at,
      bit [31:0] b, bit br, bit [5:0] bt, bit [5:0] dst);
    t.dv = 1'b1; t.op = op;
    t.a = a; t.ar = ar; t.at = at;
    t.b = b; t.br = br; t.bt = bt;
    t.dst = dst;
    return t;
  endfunction

  function automatic vec_t cdb(vec_t t, bit [5:0] ct,
      bit [31:0] cd);
    t.cv = 1'b1; t.ct = ct; t.cd = cd;
    return t;
  endfunction

  function automatic vec_t ex(vec_t t, bit dr, bit iv,
      bit [31:0] a, bit [31:0] b, bit [2:0] op, bit [5:0] dst);
    t.e_dr = dr; t.e_iv = iv;
    t.e_a = a; t.e_b = b; t.e_op = op; t.e_dst = dst;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string nm);
    logic [74:0] got, exp;
    @(negedge clk);
    reset        = t.rs;
    flush        = t.fl;
    disp_valid   = t.dv;
    disp_alucont = t.op;
    disp_a       = t.a;
    disp_b       = t.b;
    disp_a_rdy   = t.ar;
    disp_b_rdy   = t.br;
    disp_a_tag   = t.at;
    disp_b_tag   = t.bt;
    disp_dst_tag = t.dst;
    cdb_valid    = t.cv;
    cdb_tag      = t.ct;
    cdb_data     = t.cd;
    iss_ready    = t.ir;
    #1;
    if (t.chk) begin
      checks++;
      got = {disp_ready, iss_valid, iss_a, iss_b,
             iss_alucont, iss_dst_tag};
      exp = {t.e_dr, t.e_iv, t.e_a, t.e_b, t.e_op, t.e_dst};
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got dr=%0d iv=%0d a=%h b=%h op=%0d dst=%0d want dr=%0d iv=%0d a=%h b=%h op=%0d dst=%0d",
                 nm, disp_ready, iss_valid, iss_a, iss_b,
                 iss_alucont, iss_dst_tag, t.e_dr, t.e_iv,
                 t.e_a, t.e_b, t.e_op, t.e_dst);
      end
    end
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    // Reset held two cycles with a dispatch that must be ignored.
    t = dsp(nop(1'b0), ALU_ADD, 1, 1, 0, 1, 1, 0, 9);
    t.rs = 1'b1; t.chk = 1'b0;
    apply(t, "rst0");
    apply(t, "rst1");
    apply(nop(1'b0), "reset_state");

    // Basic add, issue next cycle.
    tbl.push_back(dsp(nop(1), ALU_ADD, 5, 1, 0, 7, 1, 0, 3));
    tbl.push_back(ex(nop(1), 1, 1, 5, 7, ALU_ADD, 3));
    tbl.push_back(nop(1));

    // Sub waiting on tag 9; wrong tag on CDB first.
    tbl.push_back(dsp(nop(1), ALU_SUB, 32'h50, 1, 0, 0, 0, 9, 20));
    tbl.push_back(cdb(nop(1), 8, 32'hBAD));
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    tbl.push_back(ex(cdb(nop(1), 9, 32'h20), 1, 1,
                     32'h50, 32'h20, ALU_SUB, 20));
    tbl.push_back(nop(1));
`else
    tbl.push_back(cdb(nop(1), 9, 32'h20));
    tbl.push_back(ex(nop(1), 1, 1, 32'h50, 32'h20, ALU_SUB, 20));
`endif
    tbl.push_back(nop(1));

    // Fill to full with the ALU stalled, then drain in order.
    tbl.push_back(dsp(nop(0), ALU_AND, 32'h10, 1, 0, 1, 1, 0, 1));
    tbl.push_back(ex(dsp(nop(0), ALU_OR, 32'h20, 1, 0, 2, 1, 0, 2),
                     1, 1, 32'h10, 1, ALU_AND, 1));
    tbl.push_back(ex(dsp(nop(0), ALU_SLL, 32'h30, 1, 0, 3, 1, 0, 3),
                     1, 1, 32'h10, 1, ALU_AND, 1));
    tbl.push_back(ex(dsp(nop(0), ALU_SLT, 32'h40, 1, 0, 4, 1, 0, 4),
                     1, 1, 32'h10, 1, ALU_AND, 1));
    tbl.push_back(ex(nop(0), 0, 1, 32'h10, 1, ALU_AND, 1));
    tbl.push_back(ex(dsp(nop(1), ALU_ADD, 1, 1, 0, 1, 1, 0, 9),
                     0, 1, 32'h10, 1, ALU_AND, 1));
    tbl.push_back(ex(nop(1), 1, 1, 32'h20, 2, ALU_OR, 2));
    tbl.push_back(ex(nop(1), 1, 1, 32'h30, 3, ALU_SLL, 3));
    tbl.push_back(ex(nop(1), 1, 1, 32'h40, 4, ALU_SLT, 4));
    tbl.push_back(nop(1));

    // Younger ready op bypasses an older waiting one.
    tbl.push_back(dsp(nop(1), ALU_SUB, 32'h100, 0, 5, 3, 1, 0, 7));
    tbl.push_back(dsp(nop(1), ALU_ADD, 2, 1, 0, 3, 1, 0, 8));
    tbl.push_back(ex(nop(1), 1, 1, 2, 3, ALU_ADD, 8));
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    tbl.push_back(ex(cdb(nop(1), 5, 32'h55), 1, 1,
                     32'h55, 3, ALU_SUB, 7));
`else
    tbl.push_back(cdb(nop(1), 5, 32'h55));
    tbl.push_back(ex(nop(1), 1, 1, 32'h55, 3, ALU_SUB, 7));
`endif
    tbl.push_back(nop(1));

    // Dispatch-time capture of a broadcast operand.
    tbl.push_back(cdb(dsp(nop(1), ALU_SRL, 0, 0, 12,
                          32'h80000000, 1, 0, 11), 12, 32'hDEAD));
    tbl.push_back(ex(nop(1), 1, 1, 32'hDEAD, 32'h80000000,
                     ALU_SRL, 11));
    tbl.push_back(nop(1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Flush with three held entries and a same-cycle dispatch.
    apply(dsp(nop(0), ALU_OR, 32'h21, 1, 0, 1, 1, 0, 21), "f0");
    apply(ex(dsp(nop(0), ALU_OR, 32'h22, 1, 0, 2, 1, 0, 22),
             1, 1, 32'h21, 1, ALU_OR, 21), "f1");
    apply(ex(dsp(nop(0), ALU_OR, 32'h23, 1, 0, 3, 1, 0, 23),
             1, 1, 32'h21, 1, ALU_OR, 21), "f2");
    t = ex(dsp(nop(0), ALU_OR, 32'h24, 1, 0, 4, 1, 0, 24),
           1, 1, 32'h21, 1, ALU_OR, 21);
    t.fl = 1'b1;
    apply(t, "f3_flush");
    apply(nop(0), "f4_empty");
    for (int k = 0; k < 4; k++) begin
      t = dsp(nop(0), ALU_SRA, 32'h31 + k, 1, 0, k, 1, 0,
              6'(31 + k));
      if (k != 0) t = ex(t, 1, 1, 32'h31, 0, ALU_SRA, 31);
      apply(t, $sformatf("f_fill%0d", k));
    end
    apply(ex(nop(0), 0, 1, 32'h31, 0, ALU_SRA, 31), "f_full");
    for (int k = 0; k < 4; k++) begin
      apply(ex(nop(1), (k != 0), 1, 32'h31 + k, k, ALU_SRA,
               6'(31 + k)), $sformatf("f_drain%0d", k));
    end
    apply(nop(0), "f_end");

    // Mid-run reset drops a held entry.
    apply(dsp(nop(0), ALU_AND, 32'h77, 1, 0, 8, 1, 0, 40), "r0");
    t = ex(nop(0), 1, 1, 32'h77, 8, ALU_AND, 40);
    t.rs = 1'b1;
    apply(t, "r1_reset");
    apply(nop(1), "r2_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station in front of one integer ALU in the superscalar execute stage.
- Buffers dispatched ALU ops until both operands are available, captured from the common data bus (CDB).
- Issues the oldest ready op to the ALU as operands a, b plus the 3-bit alucont code.
- It is the producer side of the ALU operand/opcode interface.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 6, width of physical/ROB tags carried on CDB and destination.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept an entry this cycle.
- disp_alucont  in  3  ALU op code (000 and, 001 or, 010 add, 011 sub, 100 sll, 101 srl, 110 sra, 111 slt).
- disp_a / disp_b  in  32 each  operand value, valid when the matching rdy bit is set.
- disp_a_rdy / disp_b_rdy  in  1 each  operand already available.
- disp_a_tag / disp_b_tag  in  TAG_W each  producer tag when not ready.
- disp_dst_tag  in  TAG_W  destination tag of this op.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast result.
- iss_valid  out  1  an issue candidate is present.
- iss_ready  in  1  ALU accepts this cycle.
- iss_a, iss_b  out  32 each  operands to ALU.
- iss_alucont  out  3  op code to ALU.
- iss_dst_tag  out  TAG_W  destination tag to ALU/CDB arbiter.

Behaviour:
- Storage is a collapsing queue: entry 0 is oldest. Valid entries occupy indices 0..count-1 contiguously. count ranges 0..DEPTH.
- Reset/flush: all entries invalid, count=0. Next cycle: iss_valid=0, disp_ready=1, iss_a=iss_b=0, iss_alucont=0, iss_dst_tag=0. Reset and flush both override a same-cycle dispatch or issue.
- disp_ready = (count < DEPTH). A same-cycle issue does not free a slot for dispatch when full.
- Dispatch fires on disp_valid && disp_ready.
  - Each operand stores value, rdy and tag.
  - If an operand is not ready and cdb_valid with cdb_tag == its tag in the same cycle, it is stored ready with cdb_data (dispatch-time capture).
- Wakeup: each cycle, every valid entry operand with rdy=0 and a tag matching a valid CDB broadcast captures cdb_data and sets rdy. The result is visible the next cycle.
- Entry ready = valid && a_rdy && b_rdy.
- Select: the lowest-index ready entry, i.e. the oldest ready op, which is not necessarily entry 0.
  - iss_* is driven combinationally from the selected entry. When no entry is ready, iss_valid=0 and iss_* hold 0.
- Issue fires on iss_valid && iss_ready. At the edge the selected entry is removed and all higher entries shift down by one. Wakeups apply to the shifted copies.
- Simultaneous dispatch + issue: count is unchanged and the new entry lands at index count-1 after collapse.
- Latency: an op dispatched with both operands ready can issue the cycle after dispatch at the earliest.
- Operand values are passed unmodified. Shift ops use iss_a as the shift amount.

Optional Feature:
- Macro ALU_RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose last missing operand matches the current CDB broadcast counts as ready this cycle. The corresponding iss_a/iss_b is muxed from cdb_data, so it issues in the wakeup cycle.
- Undefined: it issues no earlier than the cycle after the wakeup.

Decomposition:
- Package alu_rs_pkg holds:
  - the alucont_t enum (8 codes above);
  - the TAG_W default;
  - operand_t struct {rdy, tag, value};
  - rs_entry_t struct {valid, alucont, a, b, dst_tag}.
- One sub-module, alu_rs_operand, holds one operand's CDB tag compare, capture mux and bypass-ready output. It is instantiated twice per entry.

Test Plan:
- Reset, dispatch add a=5 b=7 both ready dst=3, iss_ready=1 -> next cycle iss_valid=1, iss_a=5, iss_b=7, iss_alucont=010, iss_dst_tag=3. The cycle after, iss_valid=0.
- Dispatch sub with b_rdy=0 b_tag=9, CDB tag 9 data 0x20 two cycles later -> without the macro, issue the cycle after the CDB with iss_b=0x20. With the macro, issue in the CDB cycle.
- iss_ready=0, dispatch 4 ready ops (dst 1..4) -> disp_ready=0 after the fourth. Then iss_ready=1 -> issue order dst 1,2,3,4; disp_ready=1 the cycle after the first issue.
- Entry0 waiting on tag 5, entry1 ready dst=8 -> dst 8 issues first. Entry0 stays at index 0 and issues after CDB tag 5.
- Dispatch with a_rdy=0 a_tag=12 while CDB broadcasts tag 12 data 0xDEAD -> entry stored ready, issues next cycle with iss_a=0xDEAD.
- 3 entries held, then flush asserted together with disp_valid -> next cycle count=0, iss_valid=0, disp_ready=1, and the dispatched op is dropped.
